// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronize and debounce a bouncy button into a level, edge strobes and a press counter
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn_in      : raw asynchronous button level
//   level_out   : debounced level (registered)
//   rise_pulse  : one-cycle strobe on an accepted 0->1 change (registered)
//   fall_pulse  : one-cycle strobe on an accepted 1->0 change (registered)
//   press_count : number of accepted rising changes, wraps 255->0
module debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    logic             sync_q;
    logic             btn_s_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    always_comb begin
        state_d = LOW;
        cnt_d   = '0;
        case (state_q)
            LOW: begin
                state_d = btn_s_q ? RISE_CHK : LOW;
                cnt_d   = btn_s_q ? ONE : '0;
            end
            RISE_CHK: begin
                state_d = !btn_s_q ? LOW : (cnt_q == LAST) ? HIGH : RISE_CHK;
                cnt_d   = (btn_s_q && cnt_q != LAST) ? cnt_q + ONE : '0;
            end
            HIGH: begin
                state_d = !btn_s_q ? FALL_CHK : HIGH;
                cnt_d   = !btn_s_q ? ONE : '0;
            end
            FALL_CHK: begin
                state_d = btn_s_q ? HIGH : (cnt_q == LAST) ? LOW : FALL_CHK;
                cnt_d   = (!btn_s_q && cnt_q != LAST) ? cnt_q + ONE : '0;
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end
    // Outputs are derived from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 1'b0;
            btn_s_q     <= 1'b0;
            state_q     <= LOW;
            cnt_q       <= '0;
            level_out   <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            press_count <= 8'd0;
        end else begin
            sync_q      <= btn_in;
            btn_s_q     <= sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_out   <= (state_d == HIGH) || (state_d == FALL_CHK);
            rise_pulse  <= (state_q == RISE_CHK) && (state_d == HIGH);
            fall_pulse  <= (state_q == FALL_CHK) && (state_d == LOW);
            if ((state_q == RISE_CHK) && (state_d == HIGH))
                press_count <= press_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: randomized and directed check of debounce_pulse against a run-length reference model
module tb_debounce_pulse;
    localparam int N = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b0;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] press_count;
    int tests = 0;
    int fails = 0;
    int rises = 0;
    int falls = 0;
    // model: two-stage delay line, accepted level, length of the current run of disagreeing samples
    logic m_s1, m_s2, m_lvl, m_rise, m_fall;
    int   m_run;
    int   m_cnt;

    debounce_pulse #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level_out(level_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_run = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic sample;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sample = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_in;
        m_rise = 0;
        m_fall = 0;
        if (sample != m_lvl) begin
            m_run++;
            if (m_run == N) begin
                m_lvl  = sample;
                m_rise = sample;
                m_fall = !sample;
                m_run  = 0;
                if (sample) m_cnt = (m_cnt + 1) % 256;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic compare();
        chk("level", level_out, m_lvl);
        chk("rise", rise_pulse, m_rise);
        chk("fall", fall_pulse, m_fall);
        chk("count", press_count, m_cnt);
        chk("exclusive", rise_pulse & fall_pulse, 0);
        if (rise_pulse) rises++;
        if (fall_pulse) falls++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic hold(input logic v, input int n);
        btn_in = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_level", level_out, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_count", press_count, 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int r0;
        model_reset();
        #1;
        chk("por_level", level_out, 0);
        chk("por_count", press_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        hold(0, 4);

        // bounce shorter than the qualification window
        r0 = rises;
        hold(1, 2); hold(0, 1); hold(1, 2); hold(0, 10);
        chk("bounce_rises", rises - r0, 0);
        chk("bounce_level", level_out, 0);
        chk("bounce_count", press_count, 0);

        // clean press: accepted on the sixth edge after the change
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) chk("clean_early", level_out, 0);
            if (i == 6) chk("clean_rise", rise_pulse, 1);
            if (i == 7) chk("clean_single", rise_pulse, 0);
        end
        chk("clean_count", press_count, 1);

        // release
        r0 = falls;
        btn_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) chk("release_fall", fall_pulse, 1);
        end
        chk("release_falls", falls - r0, 1);
        chk("release_level", level_out, 0);

        // glitch during qualification restarts the window
        r0 = rises;
        btn_in = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            btn_in = (i == 4) ? 1'b0 : 1'b1;
            tick();
            if (i == 9) chk("requal_early", rise_pulse, 0);
            if (i == 10) chk("requal_rise", rise_pulse, 1);
        end
        chk("requal_rises", rises - r0, 1);
        chk("requal_count", press_count, 2);
        hold(0, 10);

        // reset in the middle of a rising qualification
        hold(1, 4);
        async_reset();
        r0 = rises;
        hold(1, 12);
        chk("post_rst_rises", rises - r0, 1);
        chk("post_rst_count", press_count, 1);
        hold(0, 10);

        // randomized bouncy activity with occasional resets
        for (int k = 0; k < 400; k++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) async_reset();
        end

        // wrap of the press counter
        hold(0, 8);
        async_reset();
        hold(0, 4);
        r0 = rises;
        for (int p = 1; p <= 256; p++) begin
            hold(1, 8);
            hold(0, 8);
            if (p == 255) chk("wrap_255", press_count, 255);
        end
        chk("wrap_0", press_count, 0);
        chk("wrap_rises", rises - r0, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
